// File: rtl/game_state_controller.sv
// game_state_controller
//
// Central sequencer for the frogger game. Runs the game through IDLE, PLAY,
// DYING, LEVEL_UP and GAME_OVER, tracks remaining lives and a two-digit BCD
// level, produces the car step tick (its period shrinks with every level-up
// down to a floor) and issues the one-cycle frog-reset pulse on every entry
// into PLAY.
//
// Ports:
//   i_Clk          system clock
//   i_Reset        synchronous, active-high reset
//   i_Start        start button level (debounced)
//   i_Frog_At_Top  frog occupies the goal row (level)
//   i_Collision    frog overlaps a car (level)
//   o_Frog_Reset   one-cycle pulse, coincident with the first PLAY cycle
//   o_Cars_Enable  high only in PLAY
//   o_Car_Step     one-cycle tick, cars advance one cell per tick
//   o_Level_Tens   BCD tens digit of the level
//   o_Level_Ones   BCD ones digit of the level
//   o_Lives        remaining lives
//   o_Game_Over    high in GAME_OVER
//   o_State        IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4
//
// All outputs are registered. An input edge is captured by a sample register
// and compared against the previous sample, so the state reacts one edge
// after the input was first sampled.

module game_state_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_HOLD   = 25_000_000,
  parameter int LEVELUP_HOLD = 12_500_000,
  parameter int BASE_STEP    = 10_000_000,
  parameter int STEP_DEC     = 500_000,
  parameter int MIN_STEP     = 2_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Frog_At_Top,
  input  logic       i_Collision,
  output logic       o_Frog_Reset,
  output logic       o_Cars_Enable,
  output logic       o_Car_Step,
  output logic [3:0] o_Level_Tens,
  output logic [3:0] o_Level_Ones,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0]  LIVES_LOAD   = 2'(LIVES_INIT);
  localparam logic [24:0] DEATH_LAST   = 25'(DEATH_HOLD - 1);
  localparam logic [24:0] LEVELUP_LAST = 25'(LEVELUP_HOLD - 1);
  localparam logic [24:0] BASE_PERIOD  = 25'(BASE_STEP);
  localparam logic [24:0] PERIOD_DEC   = 25'(STEP_DEC);
  localparam logic [24:0] PERIOD_MIN   = 25'(MIN_STEP);
  // Smallest period that can still be reduced by a full STEP_DEC without
  // dropping below the floor; comparing against it avoids any underflow.
  localparam logic [24:0] PERIOD_KNEE  = 25'(MIN_STEP + STEP_DEC);

  // ---------------------------------------------------------------------
  // Rising-edge detection: bit 0 start, bit 1 at-top, bit 2 collision.
  // While in reset both stages follow the input, so a level that is
  // already high when reset releases produces no event.
  // ---------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] evt;

  assign raw_in = {i_Collision, i_Frog_At_Top, i_Start};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      logic sample_reg;
      logic prev_reg;

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          sample_reg <= raw_in[gi];
          prev_reg   <= raw_in[gi];
        end else begin
          sample_reg <= raw_in[gi];
          prev_reg   <= sample_reg;
        end
      end

      assign evt[gi] = sample_reg & ~prev_reg;
    end
  endgenerate

  logic start_evt;
  logic top_evt;
  logic col_evt;

  assign start_evt = evt[0];
  assign top_evt   = evt[1];
  assign col_evt   = evt[2];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [1:0]  lives_reg, lives_next;
  logic [3:0]  tens_reg, tens_next;
  logic [3:0]  ones_reg, ones_next;
  logic [24:0] period_reg, period_next;
  logic [24:0] step_cnt_reg, step_cnt_next;
  logic [24:0] hold_cnt_reg, hold_cnt_next;
  logic        frog_reset_reg, frog_reset_next;
  logic        cars_enable_reg, cars_enable_next;
  logic        car_step_reg, car_step_next;
  logic        game_over_reg, game_over_next;

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. In PLAY a collision takes precedence over reaching
  // the top; in the hold states every input edge is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_evt) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (col_evt) begin
          state_next = (lives_reg == 2'd1) ? ST_GAME_OVER : ST_DYING;
        end else if (top_evt) begin
          state_next = ST_LEVEL_UP;
        end
      end
      ST_DYING: begin
        if (hold_cnt_reg == DEATH_LAST) state_next = ST_PLAY;
      end
      ST_LEVEL_UP: begin
        if (hold_cnt_reg == LEVELUP_LAST) state_next = ST_PLAY;
      end
      ST_GAME_OVER: begin
        if (start_evt) state_next = ST_PLAY;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    lives_next       = lives_reg;
    tens_next        = tens_reg;
    ones_next        = ones_reg;
    period_next      = period_reg;
    step_cnt_next    = 25'd0;
    hold_cnt_next    = 25'd0;
    car_step_next    = 1'b0;
    frog_reset_next  = (state_next == ST_PLAY) && (state_reg != ST_PLAY);
    cars_enable_next = (state_next == ST_PLAY);
    game_over_next   = (state_next == ST_GAME_OVER);

    // Hold counter restarts on every state change, so each hold state
    // spends exactly its hold count in cycles.
    if ((state_next == state_reg) &&
        ((state_reg == ST_DYING) || (state_reg == ST_LEVEL_UP))) begin
      hold_cnt_next = hold_cnt_reg + 25'd1;
    end

    // Step counter only runs while PLAY continues; leaving PLAY (or
    // entering it) clears it, and no tick is issued on the way out.
    if ((state_reg == ST_PLAY) && (state_next == ST_PLAY)) begin
      if (step_cnt_reg == period_reg - 25'd1) begin
        step_cnt_next = 25'd0;
        car_step_next = 1'b1;
      end else begin
        step_cnt_next = step_cnt_reg + 25'd1;
      end
    end

    case (state_reg)
      ST_PLAY: begin
        if (col_evt) begin
          lives_next = lives_reg - 2'd1;
        end else if (top_evt) begin
          // BCD increment, saturating at 99
          if (!((tens_reg == 4'd9) && (ones_reg == 4'd9))) begin
            if (ones_reg == 4'd9) begin
              ones_next = 4'd0;
              tens_next = tens_reg + 4'd1;
            end else begin
              ones_next = ones_reg + 4'd1;
            end
          end
          period_next = (period_reg >= PERIOD_KNEE) ? (period_reg - PERIOD_DEC)
                                                    : PERIOD_MIN;
        end
      end
      ST_GAME_OVER: begin
        if (start_evt) begin
          lives_next  = LIVES_LOAD;
          tens_next   = 4'd0;
          ones_next   = 4'd0;
          period_next = BASE_PERIOD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      lives_reg       <= LIVES_LOAD;
      tens_reg        <= 4'd0;
      ones_reg        <= 4'd0;
      period_reg      <= BASE_PERIOD;
      step_cnt_reg    <= 25'd0;
      hold_cnt_reg    <= 25'd0;
      frog_reset_reg  <= 1'b0;
      cars_enable_reg <= 1'b0;
      car_step_reg    <= 1'b0;
      game_over_reg   <= 1'b0;
    end else begin
      lives_reg       <= lives_next;
      tens_reg        <= tens_next;
      ones_reg        <= ones_next;
      period_reg      <= period_next;
      step_cnt_reg    <= step_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
      frog_reset_reg  <= frog_reset_next;
      cars_enable_reg <= cars_enable_next;
      car_step_reg    <= car_step_next;
      game_over_reg   <= game_over_next;
    end
  end

  assign o_Frog_Reset  = frog_reset_reg;
  assign o_Cars_Enable = cars_enable_reg;
  assign o_Car_Step    = car_step_reg;
  assign o_Level_Tens  = tens_reg;
  assign o_Level_Ones  = ones_reg;
  assign o_Lives       = lives_reg;
  assign o_Game_Over   = game_over_reg;
  assign o_State       = state_reg;

endmodule

// File: tb/tb_game_state_controller.sv
// Testbench for game_state_controller: a table of directed vectors, hand
// sequences for step timing, period floor, BCD saturation and reset during
// a hold, then random stimulus. A behavioural model (integer level, cycles
// since PLAY entry, hold cycles remaining) is compared with every output on
// every cycle.

module tb_game_state_controller;

  localparam int LIVES_INIT   = 3;
  localparam int DEATH_HOLD   = 4;
  localparam int LEVELUP_HOLD = 3;
  localparam int BASE_STEP    = 10;
  localparam int STEP_DEC     = 3;
  localparam int MIN_STEP     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       top = 1'b0;
  logic       col = 1'b0;
  logic       frog_reset;
  logic       cars_enable;
  logic       car_step;
  logic [3:0] level_tens;
  logic [3:0] level_ones;
  logic [1:0] lives;
  logic       game_over;
  logic [2:0] state;

  always #5 clk = ~clk;

  game_state_controller #(
    .LIVES_INIT  (LIVES_INIT),
    .DEATH_HOLD  (DEATH_HOLD),
    .LEVELUP_HOLD(LEVELUP_HOLD),
    .BASE_STEP   (BASE_STEP),
    .STEP_DEC    (STEP_DEC),
    .MIN_STEP    (MIN_STEP)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Start      (start),
    .i_Frog_At_Top(top),
    .i_Collision  (col),
    .o_Frog_Reset (frog_reset),
    .o_Cars_Enable(cars_enable),
    .o_Car_Step   (car_step),
    .o_Level_Tens (level_tens),
    .o_Level_Ones (level_ones),
    .o_Lives      (lives),
    .o_Game_Over  (game_over),
    .o_State      (state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ---------------- behavioural model ----------------
  int m_state, m_lives, m_level, m_period, m_hold, m_since;
  bit m_frog, m_step;
  bit p_start, p_top, p_col;     // input value at the previous edge
  bit e_start, e_top, e_col;     // events seen, acted on at the next edge

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enter_play();
    m_state = 1;
    m_since = 0;
    m_frog  = 1'b1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_state = 0; m_lives = LIVES_INIT; m_level = 0; m_period = BASE_STEP;
      m_hold = 0; m_since = 0; m_frog = 1'b0; m_step = 1'b0;
      p_start = start; p_top = top; p_col = col;
      e_start = 1'b0; e_top = 1'b0; e_col = 1'b0;
      return;
    end
    m_frog = 1'b0;
    m_step = 1'b0;
    case (m_state)
      0: if (e_start) enter_play();
      1: begin
        m_since++;
        if (e_col) begin
          m_lives--;
          if (m_lives == 0) m_state = 4;
          else begin m_state = 2; m_hold = DEATH_HOLD; end
        end else if (e_top) begin
          if (m_level < 99) m_level++;
          m_period = (m_period - STEP_DEC < MIN_STEP) ? MIN_STEP : m_period - STEP_DEC;
          m_state = 3;
          m_hold = LEVELUP_HOLD;
        end else if (m_since % m_period == 0) begin
          m_step = 1'b1;
        end
      end
      2, 3: begin
        m_hold--;
        if (m_hold == 0) enter_play();
      end
      4: if (e_start) begin
        m_lives = LIVES_INIT; m_level = 0; m_period = BASE_STEP;
        enter_play();
      end
      default: ;
    endcase
    e_start = start & ~p_start;
    e_top   = top & ~p_top;
    e_col   = col & ~p_col;
    p_start = start; p_top = top; p_col = col;
  endtask

  // One clock: model advances on the rising edge, outputs compared on the
  // falling edge. Stimulus changes only after tick returns.
  task automatic tick();
    logic [16:0] act, exp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    act = {state, lives, level_tens, level_ones, cars_enable, game_over, frog_reset, car_step};
    exp = {3'(m_state), 2'(m_lives), 4'(m_level / 10), 4'(m_level % 10),
           m_state == 1, m_state == 4, m_frog, m_step};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model cycle=%0d got st=%0d lives=%0d lvl=%0d%0d ce=%0d go=%0d fr=%0d cs=%0d expected st=%0d lives=%0d lvl=%0d ce=%0d go=%0d fr=%0d cs=%0d",
               cyc, state, lives, level_tens, level_ones, cars_enable, game_over, frog_reset, car_step,
               m_state, m_lives, m_level, m_state == 1, m_state == 4, m_frog, m_step);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; top = 1'b0; col = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulse at-top, wait for the frog-reset on return to PLAY, then measure
  // cycles from that pulse to the first car step. per = -1 on timeout.
  task automatic levelup_measure(output int per);
    int fr_at;
    fr_at = -1;
    per = -1;
    top = 1'b1;
    tick();
    top = 1'b0;
    for (int i = 0; i < 40 && per < 0; i++) begin
      tick();
      if (fr_at < 0 && frog_reset) fr_at = i;
      else if (fr_at >= 0 && car_step) per = i - fr_at;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".state"}, state, 0);
    check({tag, ".frog_reset"}, frog_reset, 0);
    check({tag, ".cars_enable"}, cars_enable, 0);
    check({tag, ".car_step"}, car_step, 0);
    check({tag, ".tens"}, level_tens, 0);
    check({tag, ".ones"}, level_ones, 0);
    check({tag, ".lives"}, lives, LIVES_INIT);
    check({tag, ".game_over"}, game_over, 0);
  endtask

  typedef struct {
    bit s, t, c;
    int n;
    int st, lv, lvl;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int per;
    int fr_at, s1, s2, nfr;

    // {start, top, col, cycles, state, lives, level}
    tbl[0]  = '{0, 0, 0, 2, 0, 3, 0};   // idle
    tbl[1]  = '{1, 0, 0, 2, 1, 3, 0};   // start -> PLAY
    tbl[2]  = '{0, 0, 0, 3, 1, 3, 0};
    tbl[3]  = '{0, 1, 0, 2, 3, 3, 1};   // at-top -> LEVEL_UP, level 01
    tbl[4]  = '{0, 1, 0, 6, 1, 3, 1};   // held high: single event, back in PLAY
    tbl[5]  = '{0, 0, 0, 2, 1, 3, 1};
    tbl[6]  = '{0, 0, 1, 2, 2, 2, 1};   // collision -> DYING, lives 2
    tbl[7]  = '{0, 0, 0, 5, 1, 2, 1};
    tbl[8]  = '{0, 1, 1, 2, 2, 1, 1};   // simultaneous: collision wins
    tbl[9]  = '{0, 0, 0, 5, 1, 1, 1};
    tbl[10] = '{0, 0, 1, 2, 4, 0, 1};   // last life -> GAME_OVER
    tbl[11] = '{0, 0, 0, 3, 4, 0, 1};
    tbl[12] = '{1, 0, 0, 2, 1, 3, 0};   // restart
    tbl[13] = '{0, 0, 0, 2, 1, 3, 0};

    // Reset values, checked while reset is held and after release
    rst = 1'b1;
    tick();
    tick();
    check_reset_values("reset_held");
    rst = 1'b0;
    tick();
    check_reset_values("reset_release");

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].s; top = tbl[i].t; col = tbl[i].c;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d.state", i), state, tbl[i].st);
      check($sformatf("vec%0d.lives", i), lives, tbl[i].lv);
      check($sformatf("vec%0d.tens", i), level_tens, tbl[i].lvl / 10);
      check($sformatf("vec%0d.ones", i), level_ones, tbl[i].lvl % 10);
      check($sformatf("vec%0d.cars_enable", i), cars_enable, int'(tbl[i].st == 1));
      check($sformatf("vec%0d.game_over", i), game_over, int'(tbl[i].st == 4));
      $display("vec %0d: in s=%0d t=%0d c=%0d -> state=%0d lives=%0d level=%0d%0d",
               i, tbl[i].s, tbl[i].t, tbl[i].c, state, lives, level_tens, level_ones);
    end

    // Start latency and step cadence from a fresh reset
    do_reset();
    start = 1'b1;
    fr_at = -1; s1 = -1; s2 = -1; nfr = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (frog_reset) begin nfr++; if (fr_at < 0) fr_at = i; end
      if (car_step) begin
        if (s1 < 0) s1 = i;
        else if (s2 < 0) s2 = i;
      end
    end
    check("start.frog_reset_cycle", fr_at, 2);
    check("start.frog_reset_count", nfr, 1);
    check("start.first_step", s1 - fr_at, BASE_STEP);
    check("start.second_step", s2 - s1, BASE_STEP);
    $display("seq start: frog_reset at %0d, steps at %0d and %0d", fr_at, s1, s2);

    // Period shrinks 10 -> 7 -> 4, then stays at the floor
    levelup_measure(per);
    check("levelup1.period", per, 7);
    levelup_measure(per);
    check("levelup2.period", per, 4);
    levelup_measure(per);
    check("levelup3.period", per, 4);
    check("levelup3.ones", level_ones, 3);
    $display("seq period: final period %0d, level %0d%0d", per, level_tens, level_ones);

    // BCD carry and saturation
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 1; k <= 100; k++) begin
      levelup_measure(per);
      if (k == 9 || k == 10 || k == 89 || k == 90 || k == 99 || k == 100) begin
        check($sformatf("bcd%0d.tens", k), level_tens, (k > 99 ? 99 : k) / 10);
        check($sformatf("bcd%0d.ones", k), level_ones, (k > 99 ? 99 : k) % 10);
        check($sformatf("bcd%0d.returned", k), int'(per >= 0), 1);
        $display("seq bcd: level-up %0d -> level %0d%0d", k, level_tens, level_ones);
      end
    end

    // Reset on the second cycle of DYING: no frog-reset afterwards
    col = 1'b1;
    tick();
    col = 1'b0;
    tick();
    check("midhold.dying", state, 2);
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("midhold");
    rst = 1'b0;
    nfr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frog_reset) nfr++;
    end
    check("midhold.no_frog_reset", nfr, 0);
    check("midhold.idle", state, 0);
    $display("seq midhold: state=%0d lives=%0d frog_resets=%0d", state, lives, nfr);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 4) == 0) top = ~top;
      if ($urandom_range(0, 8) == 0) col = ~col;
      tick();
    end
    $display("random: %0d cycles done", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
